// File: rtl/instr_fetch.sv
// Program-counter / instruction-fetch stage feeding the control decoder.
// Optional cycle counter output enabled by defining FETCH_CYCLE_COUNT_EN.
module instr_fetch #(
  parameter int                   PC_W       = 10,
  parameter int                   INSTR_W    = 9,
  parameter int                   OPC_W      = 3,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    target,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]        cycle_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            is_halt;

  assign is_halt = (imem_rdata == HALT_INSTR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Stall outranks halt and branch; both are re-evaluated once stall drops.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_EXEC;
          pc_nxt    = start_addr;
        end
      end
      S_EXEC: begin
        if (stall) begin
          pc_nxt = pc;
        end else if (is_halt) begin
          state_nxt = S_DONE;
        end else if (branch_taken) begin
          pc_nxt = target;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  // The memory address follows the next PC directly, so a redirect costs no bubble.
  always_comb begin
    imem_addr   = pc_nxt;
    instr       = '0;
    opcode      = '0;
    instr_valid = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: imem_addr = start_addr;
      S_EXEC: begin
        instr       = imem_rdata;
        opcode      = imem_rdata[INSTR_W-1 -: OPC_W];
        instr_valid = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

`ifdef FETCH_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state != S_EXEC && start) begin
      cycle_count <= '0;
    end else if (state == S_EXEC && !stall && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected (pc, instr) per
// valid cycle, a negedge monitor pops and compares; direct checks cover state.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] start_addr;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic       stall;
  logic       branch_taken;
  logic [9:0] target;
  logic [8:0] instr;
  logic [2:0] opcode;
  logic       instr_valid;
  logic [9:0] pc;
  logic       done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  logic [8:0]  mem [1024];
  logic [18:0] expq [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .target(target), .instr(instr),
    .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .done(done)
`ifdef FETCH_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  always @(negedge clk) begin
    logic [18:0] e;
    if (instr_valid === 1'b1) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: pc=%0h instr=%0h, required no valid cycle", pc, instr);
      end else begin
        e = expq.pop_front();
        if (pc !== e[18:9] || instr !== e[8:0] || opcode !== e[8:6]) begin
          miscompares++;
          $display("FAIL fetch: pc=%0h instr=%0h opc=%0h, required pc=%0h instr=%0h opc=%0h",
                   pc, instr, opcode, e[18:9], e[8:0], e[8:6]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit ev, input logic [9:0] epc, input logic [8:0] ei);
    if (ev) expq.push_back({epc, ei});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_done(input string nm, input logic [9:0] epc);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_valid"}, 32'(instr_valid), 32'd0);
    chk({nm, "_pc"}, 32'(pc), 32'(epc));
    chk({nm, "_instr"}, 32'(instr), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    mem[10'h000] = 9'h0A3; mem[10'h001] = 9'h045; mem[10'h002] = 9'h1FF;
    mem[10'h004] = 9'h011; mem[10'h005] = 9'h033; mem[10'h006] = 9'h044;
    mem[10'h007] = 9'h08A; mem[10'h010] = 9'h1FF;
    mem[10'h020] = 9'h0C2; mem[10'h021] = 9'h1FF; mem[10'h3FF] = 9'h066;

    reset = 1'b1; start = 1'b0; start_addr = '0; stall = 1'b0;
    branch_taken = 1'b0; target = '0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(0, 0, 0);

    // Sequential fetch ending in halt
    start = 1'b1; start_addr = 10'h000;
    #1 chk("idle_imem_addr", 32'(imem_addr), 32'h000);
    cyc(0, 0, 0);
    start = 1'b0;
    chk("seq_opcode", 32'(opcode), 32'h2);
    cyc(1, 10'h000, 9'h0A3);
    cyc(1, 10'h001, 9'h045);
    cyc(1, 10'h002, 9'h1FF);
    chk_done("seq", 10'h002);
    chk("done_imem_addr", 32'(imem_addr), 32'h002);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("seq_count", 32'(cycle_count), 32'd3);
`endif
    branch_taken = 1'b1; target = 10'h055;
    cyc(0, 0, 0);
    branch_taken = 1'b0;
    chk_done("done_branch_ignored", 10'h002);

    // Branch without bubble, start ignored in EXEC
    start = 1'b1; start_addr = 10'h004;
    #1 chk("restart_imem_addr", 32'(imem_addr), 32'h004);
    cyc(0, 0, 0);
    start = 1'b0;
    chk("restart_done_clr", 32'(done), 32'd0);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("restart_count", 32'(cycle_count), 32'd0);
`endif
    branch_taken = 1'b1; target = 10'h020;
    #1 chk("branch_imem_addr", 32'(imem_addr), 32'h020);
    cyc(1, 10'h004, 9'h011);
    branch_taken = 1'b0;
    start = 1'b1; start_addr = 10'h100;
    cyc(1, 10'h020, 9'h0C2);
    start = 1'b0;
    cyc(1, 10'h021, 9'h1FF);
    chk_done("branch", 10'h021);

    // Stall outranks branch and halt
    start = 1'b1; start_addr = 10'h007;
    cyc(0, 0, 0);
    start = 1'b0;
    stall = 1'b1; branch_taken = 1'b1; target = 10'h000;
    for (int i = 0; i < 3; i++) cyc(1, 10'h007, 9'h08A);
    stall = 1'b0;
    cyc(1, 10'h007, 9'h08A);
    branch_taken = 1'b0;
    cyc(1, 10'h000, 9'h0A3);
    cyc(1, 10'h001, 9'h045);
    stall = 1'b1;
    cyc(1, 10'h002, 9'h1FF);
    stall = 1'b0;
    chk("halt_stalled_valid", 32'(instr_valid), 32'd1);
    cyc(1, 10'h002, 9'h1FF);
    chk_done("stall", 10'h002);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("stall_count", 32'(cycle_count), 32'd4);
`endif

    // Reset mid-program, then start at 0x010
    start = 1'b1; start_addr = 10'h005;
    cyc(0, 0, 0);
    start = 1'b0;
    chk("pre_reset_pc", 32'(pc), 32'h005);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1; start_addr = 10'h010;
    #1 chk("start10_imem_addr", 32'(imem_addr), 32'h010);
    cyc(0, 0, 0);
    start = 1'b0;
    chk("start10_pc", 32'(pc), 32'h010);
    chk("start10_valid", 32'(instr_valid), 32'd1);
    cyc(1, 10'h010, 9'h1FF);
    chk_done("start10", 10'h010);

    // PC wrap from max address
    start = 1'b1; start_addr = 10'h3FF;
    cyc(0, 0, 0);
    start = 1'b0;
    cyc(1, 10'h3FF, 9'h066);
    chk("wrap_pc", 32'(pc), 32'h000);
    cyc(1, 10'h000, 9'h0A3);
    cyc(1, 10'h001, 9'h045);
    cyc(1, 10'h002, 9'h1FF);
    chk_done("wrap", 10'h002);

    cyc(0, 0, 0);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC, drives a synchronous instruction memory, and presents the fetched 9-bit instruction with its 3-bit opcode field to the decoder.
- Redirects the PC on qualified branch/jump, supports stall, and runs a start/done program handshake.

Parameters:
- PC_W, 10, program counter / instruction address width
- INSTR_W, 9, instruction word width
- OPC_W, 3, opcode width; opcode is instr[INSTR_W-1 -: OPC_W]
- HALT_INSTR, 9'h1FF, instruction encoding that ends the program

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  one-cycle pulse; begins execution at start_addr
- start_addr  in  PC_W  first instruction address
- imem_addr  out  PC_W  address to synchronous instruction memory (registered read, 1-cycle latency)
- imem_rdata  in  INSTR_W  instruction returned for the previous cycle's imem_addr
- stall  in  1  hold the current instruction and PC
- branch_taken  in  1  datapath-qualified redirect (beq with ALU zero, or j)
- target  in  PC_W  redirect address, valid with branch_taken
- instr  out  INSTR_W  current instruction
- opcode  out  OPC_W  opcode field of instr, to control decoder
- instr_valid  out  1  instr is live; downstream gates regWrite/memWrite with it
- pc  out  PC_W  address of instr
- done  out  1  program halted

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-high; asserting it mid-program aborts immediately.
  - Reset values: state=IDLE, pc=0, instr_valid=0, done=0, instr=0, opcode=0.
  - imem_addr is combinational from state (see below).
- States: IDLE, EXEC, DONE.
- IDLE:
  - imem_addr=start_addr, instr_valid=0.
  - On start: pc<=start_addr, go EXEC.
  - First instruction is valid the very next cycle.
- EXEC:
  - instr=imem_rdata, opcode=instr[8:6], instr_valid=1.
  - Next-PC priority, highest first:
    - stall=1: pc holds, imem_addr=pc (re-read); instr unchanged next cycle.
    - instr==HALT_INSTR: go DONE, imem_addr=pc. The halt instruction itself is presented with instr_valid=1 for its single cycle.
    - branch_taken=1: pc<=target, imem_addr=target.
    - otherwise: pc<=pc+1, imem_addr=pc+1.
  - No bubble on taken branch, because imem_addr is driven combinationally with the next PC.
  - stall overrides both branch_taken and halt; both are re-evaluated when stall drops.
  - branch_taken is ignored outside EXEC.
- DONE:
  - done=1, instr_valid=0, instr=0, pc holds, imem_addr=pc.
  - start re-enters EXEC at start_addr and clears done on the same edge.
- Arithmetic:
  - pc+1 wraps modulo 2^PC_W (max address to 0), no flag.
  - target is used unmodified.
- start while in EXEC is ignored.
- Outside EXEC, instr=0 and opcode=0. Decoder opcode 000 asserts regWrite by default, so instr_valid gating downstream is mandatory.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- When defined:
  - Adds output cycle_count [15:0].
  - Cleared on reset and on start accepted.
  - Increments on every EXEC cycle with stall=0; saturates at 16'hFFFF.
  - Holds in DONE.
- When undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/start: assert reset mid-EXEC at pc=5 -> same cycle state IDLE, instr_valid=0, done=0. Pulse start with start_addr=10'h010 -> imem_addr=10'h010 in that cycle; next cycle pc=10'h010, instr_valid=1.
- Sequential fetch: memory holds 9'h0A3, 9'h045, 9'h1FF at 0..2, start_addr=0 -> instr 0A3 (opcode 3'b010), then 045, then 1FF. done=1 on the cycle after 1FF; pc stays 2.
- Branch: in EXEC at pc=4 drive branch_taken=1, target=10'h020 -> next cycle pc=10'h020 and instr=mem[0x20], with no invalid cycle between.
- Stall priority: pc=7 with stall=1 and branch_taken=1 held for 3 cycles -> pc=7 and instr stable throughout. Drop stall with branch_taken=1, target=0 -> next pc=0.
- Wrap: start_addr=10'h3FF, non-halt, non-branch instruction -> next pc=10'h000.
- FETCH_CYCLE_COUNT_EN: program of 3 instructions with 2 stall cycles -> cycle_count=3 in DONE. Restart -> count clears to 0.
